// File: rtl/mod_ser_pkg.sv
// Shared types and helpers for the mod-N serializer slice.
// Holds the FSM state encoding, the residue width helper and the
// single-step remainder fold used by the residue accumulator.
package mod_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Width of a remainder modulo divisor (at least one bit).
    function automatic int unsigned res_width(input int unsigned divisor);
        return (divisor > 2) ? $clog2(divisor) : 1;
    endfunction

    // fold(2*r + b): a single conditional subtraction is enough since
    // r < divisor implies 2*r + 1 < 2*divisor.
    function automatic int unsigned residue_step(input int unsigned r,
                                                 input logic        b,
                                                 input int unsigned divisor);
        int unsigned x;
        x = (r << 1) + 32'(b);
        return (x >= divisor) ? (x - divisor) : x;
    endfunction

endpackage

// File: rtl/mod_n_residue.sv
// Running remainder of the emitted MSB-first bit stream modulo DIVISOR.
// clear restarts the accumulator at 0; step folds in bit_in.
module mod_n_residue
    import mod_ser_pkg::*;
#(
    parameter int unsigned DIVISOR = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            step,
    input  logic                            bit_in,
    output logic [res_width(DIVISOR)-1:0]   residue
);

    localparam int unsigned RW = res_width(DIVISOR);

    // Accumulate r <= fold(2*r + bit) on every emitted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            residue <= '0;
        end else if (clear) begin
            residue <= '0;
        end else if (step) begin
            residue <= RW'(residue_step(32'(residue), bit_in, DIVISOR));
        end
    end

endmodule

// File: rtl/mod_n_serializer.sv
// Parallel-to-serial source for serial mod-N detectors.
// Accepts a word on valid/ready, emits it MSB-first with sof/eof strobes,
// and optionally reports the word value modulo DIVISOR.
// Optional feature: define MOD_SER_RESIDUE_EN to build the remainder
// tracker; otherwise residue, residue_valid and div_ok are tied 0.
module mod_n_serializer
    import mod_ser_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DIVISOR    = 5,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WIDTH-1:0]                word_in,
    input  logic                            word_valid,
    output logic                            word_ready,
    output logic                            ser_out,
    output logic                            ser_valid,
    output logic                            ser_sof,
    output logic                            ser_eof,
    output logic [res_width(DIVISOR)-1:0]   residue,
    output logic                            residue_valid,
    output logic                            div_ok
);

    localparam int unsigned CW       = $clog2(WIDTH);
    localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   sh_q;
    logic [CW-1:0]      bit_cnt_q;
    logic [GW-1:0]      gap_cnt_q;
    logic               accept;
    logic               last_bit;

    assign accept   = word_valid && (state_q == IDLE);
    assign last_bit = (state_q == SHIFT) && (bit_cnt_q == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; GAP is bypassed entirely when GAP_CYCLES is 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (bit_cnt_q == '0) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift register, bit counter and gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            if (accept) begin
                sh_q      <= word_in;
                bit_cnt_q <= CW'(WIDTH - 1);
            end else if (state_q == SHIFT) begin
                sh_q <= sh_q << 1;
                if (bit_cnt_q != '0) begin
                    bit_cnt_q <= bit_cnt_q - 1'b1;
                end
            end
            if (last_bit) begin
                gap_cnt_q <= GW'(GAP_LOAD);
            end else if ((state_q == GAP) && (gap_cnt_q != '0)) begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
            end
        end
    end

    // Serial outputs decoded from state; all quiet outside SHIFT.
    always_comb begin
        word_ready = (state_q == IDLE);
        ser_valid  = (state_q == SHIFT);
        ser_out    = ser_valid && sh_q[WIDTH-1];
        ser_sof    = ser_valid && (bit_cnt_q == CW'(WIDTH - 1));
        ser_eof    = last_bit;
    end

`ifdef MOD_SER_RESIDUE_EN
    localparam int unsigned RW = res_width(DIVISOR);

    logic [RW-1:0] r_acc;
    logic [RW-1:0] res_next;

    mod_n_residue #(
        .DIVISOR (DIVISOR)
    ) u_residue (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .step    (ser_valid),
        .bit_in  (ser_out),
        .residue (r_acc)
    );

    // Remainder including the bit currently on ser_out.
    always_comb begin
        res_next = RW'(residue_step(32'(r_acc), ser_out, DIVISOR));
    end

    // Capture the final remainder on the edge that closes the eof cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            residue       <= '0;
            residue_valid <= 1'b0;
            div_ok        <= 1'b0;
        end else begin
            residue_valid <= last_bit;
            if (last_bit) begin
                residue <= res_next;
                div_ok  <= (res_next == '0);
            end
        end
    end
`else
    assign residue       = '0;
    assign residue_valid = 1'b0;
    assign div_ok        = 1'b0;
`endif

endmodule

// File: tb/tb_mod_n_serializer.sv
// Self-checking bench for mod_n_serializer (WIDTH=8, DIVISOR=5).
// Two instances: GAP_CYCLES=0 and GAP_CYCLES=3. Expected bits, strobes,
// remainders and word periods come from the word value and plain arithmetic.
module tb_mod_n_serializer;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DIVISOR = 5;
`ifdef MOD_SER_RESIDUE_EN
    localparam bit RES_EN = 1'b1;
`else
    localparam bit RES_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [7:0] word0 = '0;
    logic       valid0 = 1'b0;
    logic       ready0, sout0, sval0, sof0, eof0, rv0, ok0;
    logic [2:0] res0;

    logic [7:0] word3 = '0;
    logic       valid3 = 1'b0;
    logic       ready3, sout3, sval3, sof3, eof3, rv3, ok3;
    logic [2:0] res3;

    mod_n_serializer #(.WIDTH(WIDTH), .DIVISOR(DIVISOR), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .word_in(word0), .word_valid(valid0),
        .word_ready(ready0), .ser_out(sout0), .ser_valid(sval0), .ser_sof(sof0),
        .ser_eof(eof0), .residue(res0), .residue_valid(rv0), .div_ok(ok0)
    );

    mod_n_serializer #(.WIDTH(WIDTH), .DIVISOR(DIVISOR), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .word_in(word3), .word_valid(valid3),
        .word_ready(ready3), .ser_out(sout3), .ser_valid(sval3), .ser_sof(sof3),
        .ser_eof(eof3), .residue(res3), .residue_valid(rv3), .div_ok(ok3)
    );

    int   sel = 0;
    logic o_ready, o_sout, o_sval, o_sof, o_eof, o_rv, o_ok;
    logic [2:0] o_res;

    always_comb begin
        o_ready = (sel != 0) ? ready3 : ready0;
        o_sout  = (sel != 0) ? sout3  : sout0;
        o_sval  = (sel != 0) ? sval3  : sval0;
        o_sof   = (sel != 0) ? sof3   : sof0;
        o_eof   = (sel != 0) ? eof3   : eof0;
        o_rv    = (sel != 0) ? rv3    : rv0;
        o_ok    = (sel != 0) ? ok3    : ok0;
        o_res   = (sel != 0) ? res3   : res0;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_sof = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] w);
        if (sel != 0) begin
            valid3 = v;
            word3  = w;
        end else begin
            valid0 = v;
            word0  = w;
        end
    endtask

    // Present w at a negedge where the DUT is idle, follow all 8 bits, the
    // residue cycle and any gap; returns at the first cycle ready is back.
    task automatic send_word(input logic [7:0] w, input int gap,
                             input bit hold, input bit chk_period);
        int exp_mod;
        exp_mod = int'(w) % DIVISOR;
        drive(1'b1, w);
        chk("ready_before_accept", 32'(o_ready), 32'd1);
        @(negedge clk);
        if (!hold) drive(1'b0, w);
        for (int i = 0; i < 8; i++) begin
            chk("ser_valid", 32'(o_sval), 32'd1);
            chk("ser_out", 32'(o_sout), 32'(w[7-i]));
            chk("ser_sof", 32'(o_sof), 32'(i == 0));
            chk("ser_eof", 32'(o_eof), 32'(i == 7));
            chk("ready_in_shift", 32'(o_ready), 32'd0);
            chk("rv_in_shift", 32'(o_rv), 32'd0);
            if (i == 0) begin
                if (chk_period) chk("word_period", 32'(cyc - last_sof), 32'(9 + gap));
                last_sof = cyc;
            end
            @(negedge clk);
        end
        chk("residue_valid", 32'(o_rv), 32'(RES_EN));
        chk("residue", 32'(o_res), RES_EN ? 32'(exp_mod) : 32'd0);
        chk("div_ok", 32'(o_ok), RES_EN ? 32'(exp_mod == 0) : 32'd0);
        chk("ser_valid_after", 32'(o_sval), 32'd0);
        chk("ser_out_after", 32'(o_sout), 32'd0);
        for (int g = 0; g < gap; g++) begin
            chk("ready_in_gap", 32'(o_ready), 32'd0);
            if (g > 0) chk("rv_one_cycle", 32'(o_rv), 32'd0);
            @(negedge clk);
        end
        chk("ready_reasserted", 32'(o_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] w;
        int idle;

        // Reset state.
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ser_valid", 32'(sval0), 32'd0);
        chk("rst_ser_out", 32'(sout0), 32'd0);
        chk("rst_sof_eof", 32'({sof0, eof0}), 32'd0);
        chk("rst_residue", 32'({res0, rv0, ok0}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready0), 32'd1);
        chk("rst_ready_gap", 32'(ready3), 32'd1);

        // Directed words, back to back on the zero-gap instance.
        sel = 0;
        send_word(8'h0A, 0, 1'b0, 1'b0);
        send_word(8'h07, 0, 1'b0, 1'b1);
        send_word(8'hFF, 0, 1'b0, 1'b1);

        // word_valid held high throughout: accepts exactly 9 cycles apart.
        for (int k = 0; k < 4; k++) begin
            w = 8'($urandom);
            send_word(w, 0, 1'b1, 1'b1);
        end
        drive(1'b0, 8'h00);
        @(negedge clk);

        // GAP_CYCLES=3 instance: period of 12 cycles.
        sel = 1;
        send_word(8'h0A, 3, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            w = 8'($urandom);
            send_word(w, 3, 1'b1, 1'b1);
        end
        drive(1'b0, 8'h00);
        @(negedge clk);
        sel = 0;

        // Random words with random idle spacing; remainder vs word % 5.
        for (int k = 0; k < 12; k++) begin
            w = 8'($urandom);
            send_word(w, 0, 1'($urandom_range(0, 1)), 1'b0);
            drive(1'b0, 8'h00);
            idle = int'($urandom_range(0, 2));
            for (int j = 0; j < idle; j++) begin
                @(negedge clk);
                chk("idle_quiet", 32'({o_sval, o_rv}), 32'd0);
                chk("idle_ready", 32'(o_ready), 32'd1);
            end
        end

        // Leave a nonzero remainder behind, then reset during bit 4 of 8'hA5.
        send_word(8'h07, 0, 1'b0, 1'b0);
        w = 8'hA5;
        drive(1'b1, w);
        @(negedge clk);
        drive(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("a5_bit", 32'(o_sout), 32'(w[7-i]));
            @(negedge clk);
        end
        chk("a5_bit4_valid", 32'(o_sval), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ser_valid", 32'(o_sval), 32'd0);
        chk("abort_ser_out", 32'(o_sout), 32'd0);
        chk("abort_sof_eof", 32'({o_sof, o_eof}), 32'd0);
        chk("abort_residue", 32'({o_res, o_rv, o_ok}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("no_rv_after_abort", 32'({o_rv, o_sval}), 32'd0);
        end
        send_word(8'hC3, 0, 1'b0, 1'b0);
        drive(1'b0, 8'h00);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_n_serializer.md
Name: mod_n_serializer

Overview:
- Parallel-to-serial bit-stream source for the serial divisibility detectors (the div-by-5 FSM family).
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, with framing strobes.
- Tracks the running remainder modulo DIVISOR of the bits it has emitted, so the detector's expected output is known per word.
- Sits between the stimulus or host logic and any serial mod-N detector.

Parameters:
- WIDTH, 8: word length in bits; must be at least 2.
- DIVISOR, 5: modulus for the remainder tracker; must be at least 2.
- GAP_CYCLES, 0: idle cycles inserted after each word, before word_ready reasserts.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset: one clock, asynchronous, active-low.
- word_in  input  WIDTH  parallel word to serialize.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  block can accept a word.
- ser_out  output  1  serial data bit, MSB first.
- ser_valid  output  1  ser_out carries a word bit.
- ser_sof  output  1  first bit of a word.
- ser_eof  output  1  last bit of a word.
- residue  output  RW  final word value mod DIVISOR, where RW = $clog2(DIVISOR).
- residue_valid  output  1  one-cycle pulse; residue and div_ok are updated.
- div_ok  output  1  residue == 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; shift register, bit counter, gap counter and running remainder cleared.
  - ser_out, ser_valid, ser_sof, ser_eof, residue_valid, div_ok and residue all 0; word_ready=1 once reset is released.
- States:
  - IDLE: word_ready=1, decoded from state.
  - SHIFT: WIDTH bit cycles.
  - GAP: GAP_CYCLES cycles. Skipped when GAP_CYCLES=0.
- Accept: word_valid && word_ready at posedge T0.
  - Shift register <= word_in; bit counter <= WIDTH-1; running remainder r <= 0; state -> SHIFT.
  - word_valid while not in IDLE is ignored. The source must hold the word until accepted.
- SHIFT timing:
  - In the cycle after T0: ser_valid=1, ser_sof=1, ser_out=word_in[WIDTH-1].
  - Each subsequent edge shifts the register left by one and decrements the counter.
  - ser_eof=1 in bit cycle WIDTH, when the counter is 0.
  - ser_sof and ser_eof are never both high, because WIDTH>=2.
- Remainder tracking:
  - Each SHIFT edge updates r <= fold(2*r + ser_out).
  - fold(x) = x - DIVISOR if x >= DIVISOR, else x. One subtraction suffices because 2*r + 1 < 2*DIVISOR.
  - Intermediate width is RW+1.
- Completion, on the edge closing the eof cycle:
  - residue <= fold(2*r + ser_out); div_ok <= (that value == 0).
  - residue_valid=1 for the next single cycle.
  - residue and div_ok hold until the next completion.
  - State -> GAP if GAP_CYCLES>0, else IDLE.
- Throughput:
  - The earliest next accept is in the residue_valid cycle when GAP_CYCLES=0.
  - Word period is WIDTH + 1 + GAP_CYCLES cycles.
- Outputs outside SHIFT: ser_valid=0 and ser_sof=ser_eof=0; ser_out driven 0.
- Reset mid-word: immediate abort, all outputs to reset values, no residue_valid pulse.

Optional Feature:
- Macro: MOD_SER_RESIDUE_EN.
- Defined: the remainder tracker is built and residue, residue_valid and div_ok behave as above.
- Undefined: the tracker is not synthesized; residue, residue_valid and div_ok are tied 0. Serialization and timing are unchanged.

Decomposition:
- Package mod_ser_pkg:
  - state enum {IDLE, SHIFT, GAP};
  - function residue_step(r, bit, divisor) implementing fold(2*r + bit);
  - localparam helper for RW.
- Sub-module mod_n_residue: the remainder accumulator, with clear, step and bit inputs and a residue output. Instantiated only under MOD_SER_RESIDUE_EN.

Test Plan:
- Reset then word 8'h0A (WIDTH=8, DIVISOR=5):
  - ser_out sequence 0,0,0,0,1,0,1,0, with sof on bit 1 and eof on bit 8;
  - residue=0 and div_ok=1, pulsed 9 cycles after accept.
- Word 8'h07: residue=2, div_ok=0. Word 8'hFF: residue=0, div_ok=1 (255 = 5*51).
- Back-to-back, word_valid held high with GAP_CYCLES=0: accepts spaced exactly 9 cycles apart; word_ready low throughout SHIFT.
- GAP_CYCLES=3: word_ready reasserts 3 cycles after the residue_valid cycle; period 12 cycles.
- rst_n asserted during bit 4 of 8'hA5:
  - outputs clear asynchronously, no residue_valid pulse;
  - after release, the next word serializes from its MSB.
- Chain with div_by_5 (MOD_SER_RESIDUE_EN defined), random words: at each eof bit, the detector output equals div_ok as later reported for that word.
